// File: rtl/spi_master_ctrl_if.sv
// Local-controller and SPI pin bundle for spi_master_ctrl.
// slave: the controller's own view. master: the local host plus the SPI slave device.
interface spi_master_ctrl_if;
  logic       start;
  logic [9:0] tx_frame;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    output start, tx_frame, MISO,
    input  busy, done, rd_data, rd_valid, SS_n, MOSI
  );

  modport slave (
    input  start, tx_frame, MISO,
    output busy, done, rd_data, rd_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Bit-serial SPI initiator: sends a 10-bit {cmd,data} frame and captures the read-data reply.
// Optional abort/aborted ports are enabled by defining SPI_MASTER_ABORT_EN.
module spi_master_ctrl #(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_master_ctrl_if.slave bus
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TURN_W  = $clog2(TURN_CYCLES + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, RECV, GAP} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [TURN_W-1:0]    turn_cnt_q, turn_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [DATA_W-2:0]    shadow_q, shadow_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 abort_hit;
  logic                 is_rd;

  assign is_rd = (frame_q[FRAME_W-1 -: 2] == 2'b11);

  // Next-state logic; output registers are loaded from the decoded next state
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    turn_cnt_d = turn_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shadow_d   = shadow_q;
    abort_hit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          frame_d = bus.tx_frame;
          state_d = SEL;
        end
      end
      SEL: begin
        state_d   = SHIFT;
        bit_cnt_d = CNT_W'(FRAME_W - 1);
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          if (is_rd) begin
            state_d    = TURN;
            turn_cnt_d = TURN_W'(TURN_CYCLES - 1);
          end else begin
            state_d   = GAP;
            gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          state_d   = RECV;
          bit_cnt_d = CNT_W'(DATA_W - 1);
        end else begin
          turn_cnt_d = turn_cnt_q - TURN_W'(1);
        end
      end
      RECV: begin
        shadow_d = {shadow_q[DATA_W-3:0], bus.MISO};
        if (bit_cnt_q == '0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
        end else begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SPI_MASTER_ABORT_EN
    // Abort overrides any active-frame transition and releases the slave
    if (abort && (state_q == SEL || state_q == SHIFT || state_q == TURN || state_q == RECV)) begin
      state_d   = GAP;
      gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
      abort_hit = 1'b1;
    end
`endif
  end

  // Registered pin/status values derived from the state being entered
  always_comb begin
    ss_n_d     = (state_d == IDLE) || (state_d == GAP);
    busy_d     = (state_d != IDLE);
    mosi_d     = 1'b0;
    if (state_d == SEL) begin
      mosi_d = frame_d[FRAME_W-1];
    end else if (state_d == SHIFT) begin
      mosi_d = frame_d[bit_cnt_d];
    end
    done_d     = (state_d == GAP) && (state_q != GAP) && !abort_hit;
    rd_valid_d = done_d && is_rd;
    rd_data_d  = rd_data_q;
    if ((state_q == RECV) && (state_d == GAP) && !abort_hit) begin
      rd_data_d = {shadow_q, bus.MISO};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      turn_cnt_q <= '0;
      gap_cnt_q  <= '0;
      shadow_q   <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      shadow_q   <= shadow_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef SPI_MASTER_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= abort_hit;
    end
  end

  assign aborted = aborted_q;
`endif

  assign bus.SS_n     = ss_n_q;
  assign bus.MOSI     = mosi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural SPI slave + RAM model.
module tb_spi_master_ctrl;
  localparam int TURN   = 2;
  localparam int GAP    = 1;
  localparam int WR_LOW = 11;
  localparam int RD_LOW = 11 + TURN + 8;

  typedef struct {
    logic [10:0] mosi;
    int          low;
    int          lat;
    logic        is_rd;
    logic [7:0]  rdd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] rd_model = 8'h00;
  exp_t sb_q[$];

  spi_master_ctrl_if bus();

`ifdef SPI_MASTER_ABORT_EN
  logic abort;
  logic aborted;
`endif

  spi_master_ctrl #(.TURN_CYCLES(TURN), .GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus)
`ifdef SPI_MASTER_ABORT_EN
    ,
    .abort   (abort),
    .aborted (aborted)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor and SPI slave model, all sampled on the falling edge
  int          low_cnt  = 0;
  int          high_cnt = 0;
  int          last_low = 0;
  int          frames   = 0;
  int          done_cnt = 0;
  int          high_q[$];
  logic [10:0] mosi_cap = '0;
  logic [7:0]  sl_mem [256];
  logic [7:0]  sl_addr = 8'h00;
  logic        sl_read = 1'b0;
  logic [7:0]  sl_byte = 8'h00;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (!rst_n) begin
      low_cnt = 0;
      sl_read = 1'b0;
      bus.MISO = 1'b0;
      sl_mem[8'h3C] = 8'hC3;
    end else if (bus.SS_n === 1'b0) begin
      if (low_cnt == 0) begin
        frames++;
        high_q.push_back(high_cnt);
        sl_read = 1'b0;
      end
      if (low_cnt < 11) mosi_cap[10-low_cnt] = bus.MOSI;
      if (low_cnt == 10) begin
        case (mosi_cap[9:8])
          2'b00: sl_addr = mosi_cap[7:0];
          2'b01: sl_mem[sl_addr] = mosi_cap[7:0];
          2'b10: sl_addr = mosi_cap[7:0];
          default: begin
            sl_read = 1'b1;
            sl_byte = sl_mem[sl_addr];
          end
        endcase
      end
      if (sl_read && low_cnt >= 11 + TURN && low_cnt < RD_LOW) bus.MISO = sl_byte[RD_LOW-1-low_cnt];
      else bus.MISO = 1'b0;
      low_cnt++;
    end else begin
      if (low_cnt != 0) begin
        last_low = low_cnt;
        low_cnt  = 0;
        high_cnt = 0;
      end
      high_cnt++;
      bus.MISO = 1'b0;
    end
  end

  function automatic logic [10:0] exp_bits(input logic [9:0] f);
    return {f[9], f};
  endfunction

  // Drive one frame, push its expectation, then pop and compare on done
  task automatic send_frame(input logic [9:0] f, input logic [10:0] exp_mosi, input logic [7:0] exp_rd);
    exp_t e;
    int   n;
    e.mosi  = exp_mosi;
    e.is_rd = (f[9:8] == 2'b11);
    e.rdd   = exp_rd;
    e.low   = e.is_rd ? RD_LOW : WR_LOW;
    e.lat   = e.low + 1;
    sb_q.push_back(e);
    @(negedge clk);
    bus.tx_frame = f;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.tx_frame = ~f;
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_start: got %b want 1", bus.busy);
        end
      end
    end
    #1;
    e = sb_q.pop_front();
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL done_latency frame=%h: got %0d want %0d", f, n, e.lat);
    end
    checks++;
    if (mosi_cap !== e.mosi) begin
      errors++;
      $display("FAIL mosi_seq frame=%h: got %b want %b", f, mosi_cap, e.mosi);
    end
    checks++;
    if (last_low != e.low) begin
      errors++;
      $display("FAIL ss_low_len frame=%h: got %0d want %0d", f, last_low, e.low);
    end
    checks++;
    if (bus.rd_valid !== e.is_rd) begin
      errors++;
      $display("FAIL rd_valid frame=%h: got %b want %b", f, bus.rd_valid, e.is_rd);
    end
    checks++;
    if (bus.rd_data !== e.rdd) begin
      errors++;
      $display("FAIL rd_data frame=%h: got %h want %h", f, bus.rd_data, e.rdd);
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_release frame=%h: got %b want 0", f, bus.busy);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n: got %b want 1", bus.SS_n); end
    checks++;
    if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", bus.MOSI); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++;
    if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_addr;
    send_frame(10'b00_1010_0101, 11'b000_1010_0101, rd_model);
  endtask

  task automatic test_read_data;
    send_frame(10'b10_0011_1100, exp_bits(10'b10_0011_1100), rd_model);
    rd_model = 8'hC3;
    send_frame(10'b11_0000_0000, 11'b111_0000_0000, rd_model);
  endtask

  task automatic test_reset_mid_frame;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    bus.tx_frame = 10'b11_0000_0000;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (11 + TURN + 3) @(negedge clk);
    checks++;
    if (bus.SS_n !== 1'b0) begin errors++; $display("FAIL mid_ss_low: got %b want 0", bus.SS_n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL mid_rst_ss_n: got %b want 1", bus.SS_n); end
    checks++;
    if (bus.MOSI !== 1'b0) begin errors++; $display("FAIL mid_rst_mosi: got %b want 0", bus.MOSI); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst_rd_data: got %h want 00", bus.rd_data); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_model = 8'h00;
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL mid_rst_no_done: got %0d want %0d", done_cnt - d0, 0); end
  endtask

  task automatic test_back_to_back;
    int base;
    int d0;
    int n;
    base = frames;
    d0   = done_cnt;
    @(negedge clk);
    bus.tx_frame = 10'b00_1010_1010;
    bus.start    = 1'b1;
    n = 0;
    while (frames < base + 3 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    n = 0;
    while ((done_cnt < d0 + 3 || bus.busy !== 1'b0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (frames - base != 3) begin errors++; $display("FAIL b2b_frames: got %0d want 3", frames - base); end
    checks++;
    if (done_cnt - d0 != 3) begin errors++; $display("FAIL b2b_done: got %0d want 3", done_cnt - d0); end
    checks++;
    if (high_q[$] < GAP + 1) begin errors++; $display("FAIL b2b_gap3: got %0d want >=%0d", high_q[$], GAP + 1); end
    checks++;
    if (high_q[$-1] < GAP + 1) begin errors++; $display("FAIL b2b_gap2: got %0d want >=%0d", high_q[$-1], GAP + 1); end
  endtask

  task automatic test_loopback;
    send_frame(10'b00_0001_0010, exp_bits(10'b00_0001_0010), rd_model);
    send_frame(10'b01_0101_1010, exp_bits(10'b01_0101_1010), rd_model);
    send_frame(10'b10_0001_0010, exp_bits(10'b10_0001_0010), rd_model);
    rd_model = 8'h5A;
    send_frame(10'b11_0000_0000, exp_bits(10'b11_0000_0000), rd_model);
  endtask

`ifdef SPI_MASTER_ABORT_EN
  task automatic test_abort;
    int d0;
    logic [9:0] f;
    f  = 10'b01_1110_1111;
    d0 = done_cnt;
    @(negedge clk);
    bus.tx_frame = f;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (bus.MOSI !== f[4]) begin errors++; $display("FAIL abort_bit4: got %b want %b", bus.MOSI, f[4]); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.SS_n !== 1'b1) begin errors++; $display("FAIL abort_ss_n: got %b want 1", bus.SS_n); end
    checks++;
    if (aborted !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b want 1", aborted); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
    checks++;
    if (bus.rd_data !== rd_model) begin errors++; $display("FAIL abort_rd_data: got %h want %h", bus.rd_data, rd_model); end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.tx_frame = '0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_write_addr();
    test_read_data();
    test_reset_mid_frame();
    test_back_to_back();
    test_loopback();
`ifdef SPI_MASTER_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
